// File: rtl/jump_physics_if.sv
// Bundles the frame/button inputs and the motion outputs of the runner's jump engine.
// The controller side (debouncer/bench) uses master; the physics engine uses slave.
interface jump_physics_if #(
  parameter int H_W  = 10,
  parameter int V_W  = 8,
  parameter int JU_W = 2
);
  logic                  frame_tick;
  logic                  jump_req;
  logic                  duck;
  logic                  freeze;
  logic [H_W-1:0]        height;
  logic signed [V_W-1:0] vel;
  logic [1:0]            jumpstate;
  logic [JU_W-1:0]       jumps_used;
  logic                  landed;

  modport master (
    output frame_tick, jump_req, duck, freeze,
    input  height, vel, jumpstate, jumps_used, landed
  );

  modport slave (
    input  frame_tick, jump_req, duck, freeze,
    output height, vel, jumpstate, jumps_used, landed
  );
endinterface

// File: rtl/jump_physics.sv
// Vertical-motion engine for the runner sprite: integrates signed velocity under gravity
// once per frame, with multi-jump, fast-fall, ceiling clamp and a freeze hold.
module jump_physics #(
  parameter int H_W       = 10,
  parameter int V_W       = 8,
  parameter int V0        = 20,
  parameter int G         = 1,
  parameter int DUCK_MUL  = 3,
  parameter int H_MAX     = 400,
  parameter int MAX_JUMPS = 2
) (
  input logic          clk,
  input logic          rst_n,
  jump_physics_if.slave phys
);

  localparam int JU_W = $clog2(MAX_JUMPS + 1);
  localparam int SW   = H_W + 2;

  localparam logic [V_W-1:0]        V0_V    = V_W'(V0);
  localparam logic [V_W-1:0]        V_MIN   = {1'b1, {(V_W-1){1'b0}}};
  localparam logic [V_W:0]          G_NORM  = (V_W+1)'(G);
  localparam logic [V_W:0]          G_DUCK  = (V_W+1)'(G * DUCK_MUL);
  localparam logic [H_W-1:0]        H_MAX_H = H_W'(H_MAX);
  localparam logic signed [SW-1:0]  H_MAX_S = SW'(H_MAX);
  localparam logic [JU_W-1:0]       MAX_J   = JU_W'(MAX_JUMPS);
  localparam logic [JU_W-1:0]       ONE_J   = JU_W'(1);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } jstate_e;

  jstate_e          state_q, state_d;
  logic [H_W-1:0]   height_q, height_d;
  logic [V_W-1:0]   vel_q, vel_d;
  logic [JU_W-1:0]  ju_q, ju_d;
  logic             landed_q, landed_d;
  logic             pending_q, pending_d;
  logic             jump_prev_q;

  logic                 jump_edge;
  logic signed [SW-1:0] sum;
  logic                 touch_down;
  logic                 hit_ceiling;
  logic [V_W:0]         grav;
  logic [V_W:0]         diff;
  logic [V_W-1:0]       vel_grav;
  logic                 vel_pos;

  // Height/velocity arithmetic is done one bit wider than height plus a sign bit so
  // a fall through the ground or a climb past the ceiling is visible before clamping.
  always_comb begin
    jump_edge   = phys.jump_req & ~jump_prev_q;
    sum         = $signed({2'b00, height_q}) + $signed({{(SW-V_W){vel_q[V_W-1]}}, vel_q});
    touch_down  = sum[SW-1] | (sum == '0);
    hit_ceiling = sum > H_MAX_S;
    grav        = phys.duck ? G_DUCK : G_NORM;
    diff        = {vel_q[V_W-1], vel_q} - grav;
    vel_grav    = (diff[V_W] != diff[V_W-1]) ? V_MIN : diff[V_W-1:0];
    vel_pos     = ~vel_grav[V_W-1] & (vel_grav != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GROUND;
      height_q    <= '0;
      vel_q       <= '0;
      ju_q        <= '0;
      landed_q    <= 1'b0;
      pending_q   <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      vel_q       <= vel_d;
      ju_q        <= ju_d;
      landed_q    <= landed_d;
      pending_q   <= pending_d;
      jump_prev_q <= phys.jump_req;
    end
  end

  // A request edge arriving on a tick is only latched here; it is consumed on the following
  // tick. Landing wins over a re-jump and leaves the pending request for the next launch.
  always_comb begin
    state_d   = state_q;
    height_d  = height_q;
    vel_d     = vel_q;
    ju_d      = ju_q;
    landed_d  = 1'b0;
    pending_d = pending_q | jump_edge;

    if (phys.freeze) begin
      pending_d = 1'b0;
    end else if (phys.frame_tick) begin
      case (state_q)
        GROUND: begin
          if (pending_q) begin
            vel_d     = V0_V;
            state_d   = RISE;
            ju_d      = ONE_J;
            pending_d = jump_edge;
          end
        end
        default: begin
          if (touch_down) begin
            height_d = '0;
            vel_d    = '0;
            state_d  = GROUND;
            ju_d     = '0;
            landed_d = 1'b1;
          end else if (hit_ceiling) begin
            height_d = H_MAX_H;
            vel_d    = '0;
            state_d  = FALL;
          end else begin
            height_d = sum[H_W-1:0];
            if (pending_q && (ju_q < MAX_J)) begin
              vel_d     = V0_V;
              ju_d      = ju_q + ONE_J;
              state_d   = RISE;
              pending_d = jump_edge;
            end else begin
              vel_d   = vel_grav;
              state_d = vel_pos ? RISE : FALL;
              if (pending_q) begin
                pending_d = jump_edge;
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    phys.height     = height_q;
    phys.vel        = vel_q;
    phys.jumpstate  = state_q;
    phys.jumps_used = ju_q;
    phys.landed     = landed_q;
  end

endmodule

// File: tb/tb_jump_physics.sv
// Scoreboard bench for jump_physics: each frame tick pushes its hand-computed result and a
// monitor pops and compares on the cycle after every tick. Two instances cover two ceilings.
module tb_jump_physics;

  localparam int H_W  = 10;
  localparam int V_W  = 8;
  localparam int JU_W = 2;

  typedef struct {
    int h;
    int v;
    int st;
    int ju;
    int ld;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jump_physics_if #(.H_W(H_W), .V_W(V_W), .JU_W(JU_W)) if_a ();
  jump_physics_if #(.H_W(H_W), .V_W(V_W), .JU_W(JU_W)) if_b ();

  jump_physics #(
    .H_W(H_W), .V_W(V_W), .V0(4), .G(1), .DUCK_MUL(2), .H_MAX(100), .MAX_JUMPS(2)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .phys (if_a)
  );

  jump_physics #(
    .H_W(H_W), .V_W(V_W), .V0(4), .G(1), .DUCK_MUL(2), .H_MAX(8), .MAX_JUMPS(2)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .phys (if_b)
  );

  int   tests  = 0;
  int   errors = 0;
  int   sel    = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic seen_a = 1'b0;
  logic seen_b = 1'b0;

  task automatic check_field(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input exp_t e, input int h, input int v,
                              input int st, input int ju, input int ld);
    check_field({tag, " height"}, h, e.h);
    check_field({tag, " vel"}, v, e.v);
    check_field({tag, " jumpstate"}, st, e.st);
    check_field({tag, " jumps_used"}, ju, e.ju);
    check_field({tag, " landed"}, ld, e.ld);
  endtask

  always @(posedge clk) begin
    seen_a <= if_a.frame_tick;
    seen_b <= if_b.frame_tick;
  end

  // Monitor: results appear the cycle after a tick; on all other cycles landed must be low.
  always @(negedge clk) begin
    exp_t e;
    if (seen_a) begin
      if (q_a.size() == 0) begin
        tests++;
        errors++;
        $display("[TB] FAIL A unexpected tick: got result, expected none queued");
      end else begin
        e = q_a.pop_front();
        check_output("A", e, int'(if_a.height), int'(if_a.vel), int'(if_a.jumpstate),
                     int'(if_a.jumps_used), int'(if_a.landed));
      end
    end else if (rst_n) begin
      check_field("A landed idle", int'(if_a.landed), 0);
    end
    if (seen_b) begin
      if (q_b.size() == 0) begin
        tests++;
        errors++;
        $display("[TB] FAIL B unexpected tick: got result, expected none queued");
      end else begin
        e = q_b.pop_front();
        check_output("B", e, int'(if_b.height), int'(if_b.vel), int'(if_b.jumpstate),
                     int'(if_b.jumps_used), int'(if_b.landed));
      end
    end else if (rst_n) begin
      check_field("B landed idle", int'(if_b.landed), 0);
    end
  end

  task automatic set_tick(input logic b);
    if (sel == 0) if_a.frame_tick = b;
    else          if_b.frame_tick = b;
  endtask

  task automatic set_jump(input logic b);
    if (sel == 0) if_a.jump_req = b;
    else          if_b.jump_req = b;
  endtask

  task automatic press();
    @(posedge clk);
    #1 set_jump(1'b1);
    @(posedge clk);
    #1 set_jump(1'b0);
  endtask

  // One frame: queue the expected result, pulse frame_tick (optionally with a button edge
  // on the same cycle), then idle so ticks are 8 clocks apart.
  task automatic apply_stimulus(input exp_t e, input bit with_press);
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    @(posedge clk);
    #1;
    set_tick(1'b1);
    if (with_press) set_jump(1'b1);
    @(posedge clk);
    #1;
    set_tick(1'b0);
    set_jump(1'b0);
    repeat (6) @(posedge clk);
  endtask

  task automatic check_zero(input string tag, input int h, input int v, input int st,
                            input int ju, input int ld);
    exp_t z;
    z = '{0, 0, 0, 0, 0};
    check_output(tag, z, h, v, st, ju, ld);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t single[9];
    exp_t dbl[12];
    exp_t ceil_seq[5];
    exp_t ceil_duck[3];
    exp_t gnd;

    single = '{'{0, 4, 1, 1, 0}, '{4, 3, 1, 1, 0}, '{7, 2, 1, 1, 0}, '{9, 1, 1, 1, 0},
               '{10, 0, 2, 1, 0}, '{10, -1, 2, 1, 0}, '{9, -2, 2, 1, 0}, '{7, -3, 2, 1, 0},
               '{4, -4, 2, 1, 0}};
    dbl = '{'{13, 3, 1, 2, 0}, '{16, 2, 1, 2, 0}, '{18, 1, 1, 2, 0}, '{19, 0, 2, 2, 0},
            '{19, -1, 2, 2, 0}, '{18, -2, 2, 2, 0}, '{16, -3, 2, 2, 0}, '{13, -4, 2, 2, 0},
            '{9, -5, 2, 2, 0}, '{4, -6, 2, 2, 0}, '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0}};
    ceil_seq = '{'{0, 4, 1, 1, 0}, '{4, 3, 1, 1, 0}, '{7, 2, 1, 1, 0}, '{8, 0, 2, 1, 0},
                 '{8, -1, 2, 1, 0}};
    ceil_duck = '{'{7, -3, 2, 1, 0}, '{4, -5, 2, 1, 0}, '{0, 0, 0, 0, 1}};
    gnd = '{0, 0, 0, 0, 0};

    if_a.frame_tick = 1'b0; if_a.jump_req = 1'b0; if_a.duck = 1'b0; if_a.freeze = 1'b0;
    if_b.frame_tick = 1'b0; if_b.jump_req = 1'b0; if_b.duck = 1'b0; if_b.freeze = 1'b0;

    #12;
    check_zero("A reset", int'(if_a.height), int'(if_a.vel), int'(if_a.jumpstate),
               int'(if_a.jumps_used), int'(if_a.landed));
    check_zero("B reset", int'(if_b.height), int'(if_b.vel), int'(if_b.jumpstate),
               int'(if_b.jumps_used), int'(if_b.landed));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single jump, then a button edge on the landing tick relaunches on the next tick.
    sel = 0;
    press();
    for (int i = 0; i < 9; i++) apply_stimulus(single[i], 1'b0);
    apply_stimulus('{0, 0, 0, 0, 1}, 1'b1);
    apply_stimulus(single[0], 1'b0);
    for (int i = 1; i < 9; i++) apply_stimulus(single[i], 1'b0);
    apply_stimulus('{0, 0, 0, 0, 1}, 1'b0);
    apply_stimulus(gnd, 1'b0);

    // Double jump; a third press while out of jumps must be dropped.
    press();
    for (int i = 0; i < 3; i++) apply_stimulus(single[i], 1'b0);
    press();
    apply_stimulus('{9, 4, 1, 2, 0}, 1'b0);
    press();
    for (int i = 0; i < 12; i++) apply_stimulus(dbl[i], 1'b0);

    // Freeze mid-air with a press inside the freeze, then resume and reset mid-air.
    press();
    for (int i = 0; i < 3; i++) apply_stimulus(single[i], 1'b0);
    if_a.freeze = 1'b1;
    if_b.freeze = 1'b1;
    press();
    for (int i = 0; i < 5; i++) apply_stimulus('{7, 2, 1, 1, 0}, 1'b0);
    @(posedge clk);
    #1;
    if_a.freeze = 1'b0;
    if_b.freeze = 1'b0;
    apply_stimulus('{9, 1, 1, 1, 0}, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_zero("A async reset", int'(if_a.height), int'(if_a.vel), int'(if_a.jumpstate),
               int'(if_a.jumps_used), int'(if_a.landed));
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(gnd, 1'b0);

    // Ceiling clamp at 8 on the second instance, then fast-fall with duck held.
    sel = 1;
    press();
    for (int i = 0; i < 5; i++) apply_stimulus(ceil_seq[i], 1'b0);
    if_b.duck = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(ceil_duck[i], 1'b0);
    if_b.duck = 1'b0;
    apply_stimulus(gnd, 1'b0);

    repeat (4) @(posedge clk);
    check_field("queue drained", q_a.size() + q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/jump_physics.md
Name: jump_physics

Overview:
- Parametrised vertical-motion engine for the VGA runner character. Successor to the fixed 2-bit jump-state/height block.
- Integrates signed velocity under configurable gravity once per video frame.
- Supports multi-jump, fast-fall (duck), a ceiling clamp and a freeze (game-over) hold.
- Sits between the keyboard/button debouncer and the sprite renderer; `height` feeds the renderer's y-offset.

Parameters:
- H_W, 10, height width (unsigned pixels)
- V_W, 8, velocity width (signed two's complement, px/frame)
- V0, 20, launch velocity applied on each accepted jump (positive, < 2^(V_W-1))
- G, 1, gravity decrement per frame
- DUCK_MUL, 3, gravity multiplier while duck held in air
- H_MAX, 400, ceiling height (< 2^H_W)
- MAX_JUMPS, 2, jumps allowed before landing (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame; all physics updates occur only on this cycle
- jump_req  in  1  jump button level (synchronous, debounced)
- duck  in  1  fast-fall request level
- freeze  in  1  hold all physics state (game over / pause)
- height  out  H_W  current height above ground
- vel  out  V_W  current signed velocity
- jumpstate  out  2  00 GROUND, 01 RISE, 10 FALL; 11 never driven
- jumps_used  out  clog2(MAX_JUMPS+1)  jumps taken since last landing
- landed  out  1  one-cycle pulse on the landing cycle

Behaviour:
- Reset (async, rst_n=0): height=0, vel=0, jumpstate=GROUND, jumps_used=0, landed=0, pending=0, jump_req edge register=0. All outputs are registered.
- Edge detect: a rising edge of jump_req (registered previous value) sets `pending`. Only one request is held; further edges while pending are absorbed.
- Non-tick cycles: only `pending` and the edge register update. `landed` is forced to 0.
- freeze=1: all state holds, frame_tick is ignored, edges are ignored and pending is cleared. The freeze_prev register is not needed.
- Tick in GROUND:
  - pending=1 → vel<=V0, jumpstate<=RISE, jumps_used<=1, pending<=0, height stays 0.
  - Otherwise nothing changes.
- Tick in RISE/FALL. Compute s = height + vel at width H_W+2, signed; g = duck ? G*DUCK_MUL : G.
  - Landing (s ≤ 0): height<=0, vel<=0, jumpstate<=GROUND, jumps_used<=0, landed<=1 for this cycle. Landing has priority over a re-jump. pending is NOT consumed, so a request pending at touchdown launches on the next tick.
  - Ceiling (s > H_MAX): height<=H_MAX, vel<=0 (no gravity this tick), jumpstate<=FALL.
  - Else, pending=1 and jumps_used<MAX_JUMPS: height<=s, vel<=V0, jumps_used++, jumpstate<=RISE, pending<=0.
  - Else: height<=s, vel<=vel−g, saturating at −2^(V_W−1); jumpstate<=RISE if the new vel>0, else FALL.
  - In the two non-ceiling air cases, a pending request with jumps_used==MAX_JUMPS is discarded (pending<=0).
- A tick coinciding with a jump_req edge: the edge sets pending this cycle. It is consumed on the next tick, not the current one.
- Reset mid-air returns immediately to GROUND state with all values zero. No landed pulse is produced.

Test Plan:
- Bench parameters: V0=4, G=1, DUCK_MUL=2, H_MAX=100, MAX_JUMPS=2. Ticks every 8 clocks.
- Single jump: one edge before tick0 → (h,v) per tick: (0,4),(4,3),(7,2),(9,1),(10,0)FALL,(10,−1),(9,−2),(7,−3),(4,−4). Tick9: h=0, GROUND, landed high exactly 1 clk, jumps_used=0.
- Double jump: edge before tick0, second edge after tick2 (h=7,v=2) → tick3 h=9, v=4, RISE, jumps_used=2. Third edge while airborne is discarded; the following trajectory is unaffected.
- Ceiling and duck: H_MAX=8 → tick3 h=8, v=0, FALL; tick4 h=8, v=−1. Assert duck from tick4 → tick5 h=7, v=−3.
- Freeze: assert freeze at h=7 for 5 ticks and pulse jump_req → height, vel, state and jumps_used unchanged, no jump after release. Release → trajectory resumes from (7,2).
- Reset mid-air plus landing/request overlap: drop rst_n asynchronously mid-cycle at h=9 → all outputs 0 within the same cycle. Separately, an edge during the landing tick → GROUND, then RISE with v=4 on the next tick.
